// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are registered into the ALU. The result is captured and returned with the winner's ID.
module alu_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [2:0]       req0_op,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic             rsp_id,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [N-1:0]     alu_y,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q;
  logic               grant_id;
  logic               accept;
  logic               rsp_valid_q;
  logic [N-1:0]       rsp_data_q;
  logic               rsp_id_q;
  logic [N-1:0]       alu_a_q, alu_b_q;
  logic [2:0]         alu_op_q;
  logic [CNT_W-1:0]   op_count_q;

  // With both requesting, the one that did not win last time gets the grant.
  assign grant_id = (&req_valid) ? ~last_grant_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      op_count_q   <= '0;
    end else begin
      if (accept) begin
        alu_a_q      <= grant_id ? req1_a : req0_a;
        alu_b_q      <= grant_id ? req1_b : req0_b;
        alu_op_q     <= grant_id ? req1_op : req0_op;
        rsp_id_q     <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_data_q  <= alu_y;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 1'b1;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign op_count   = op_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter. A local ALU model stands in for the external aluvol2.
// A transaction-level reference (winner rule, modulo counter) predicts every response.
module tb_alu_arbiter;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [N-1:0]  rsp_data, alu_a, alu_b, alu_y;
  logic [2:0]    alu_opcode;
  logic [CW-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_last   = 1'b1;
  int m_cnt    = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = {a[6:0], 1'b0};
      default: r = {1'b0, a[7:1]};
    endcase
    return r;
  endfunction

  assign alu_y = alu_ref(alu_a, alu_b, alu_opcode);

  alu_arbiter #(.N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_y(alu_y),
    .busy(busy), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transaction; stall = RESP cycles with rsp_ready low.
  task automatic do_op(input bit v0, input bit v1,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] o0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] o1,
                       input int stall);
    bit w;
    logic [7:0] ea, eb, ey;
    logic [2:0] eo;
    w  = (v0 && v1) ? ~m_last : v1;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    eo = w ? o1 : o0;
    ey = alu_ref(ea, eb, eo);
    req_valid = {v1, v0};
    req0_a = a0; req0_b = b0; req0_op = o0;
    req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready = (stall == 0);
    #1;
    check("grant", 32'(req_ready), w ? 32'd2 : 32'd1);
    check("busy_idle", 32'(busy), 0);
    @(posedge clk); #1;
    check("alu_a", 32'(alu_a), 32'(ea));
    check("alu_b", 32'(alu_b), 32'(eb));
    check("alu_opcode", 32'(alu_opcode), 32'(eo));
    check("exec_rsp_valid", 32'(rsp_valid), 0);
    check("exec_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_data", 32'(rsp_data), 32'(ey));
    check("rsp_id", 32'(rsp_id), 32'(w));
    check("busy_resp", 32'(busy), 1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_data", 32'(rsp_data), 32'(ey));
      check("hold_id", 32'(rsp_id), 32'(w));
      check("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    m_last = w;
    m_cnt  = (m_cnt + 1) % 16;
    check("done_valid", 32'(rsp_valid), 0);
    check("op_count", 32'(op_count), 32'(m_cnt));
    check("busy_done", 32'(busy), 0);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
  endtask

  task automatic rand_op(input bit both, input int max_stall);
    bit v0, v1;
    if (both) begin
      v0 = 1'b1; v1 = 1'b1;
    end else begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
    end
    do_op(v0, v1, 8'($urandom), 8'($urandom), 3'($urandom),
          8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(max_stall));
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_opcode), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 0);

    do_op(1, 0, 8'd73, 8'd42, 3'd0, 8'd0, 8'd0, 3'd0, 0);
    for (int op = 0; op < 8; op++) begin
      do_op(1, 0, 8'd73, 8'd42, 3'(op), 8'd0, 8'd0, 3'd0, 0);
      do_op(0, 1, 8'd0, 8'd0, 3'd0, 8'd73, 8'd42, 3'(op), 0);
    end
    for (int i = 0; i < 6; i++) rand_op(1'b1, 0);
    do_op(1, 1, 8'd200, 8'd100, 3'd1, 8'd15, 8'd240, 3'd4, 5);
    for (int i = 0; i < 30; i++) rand_op(1'b0, 3);

    // Reset while the ALU operation is in flight.
    req_valid = 2'b01; req0_a = 8'd9; req0_b = 8'd3; req0_op = 3'd0;
    @(posedge clk); #1;
    check("exec_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_op_count", 32'(op_count), 0);
    check("midrst_alu_a", 32'(alu_a), 0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1'b1;
    m_cnt  = 0;
    do_op(0, 1, 8'd0, 8'd0, 3'd0, 8'd5, 8'd6, 3'd0, 0);

    // Counter wrap: 16 more ops after the one above makes 17 since reset.
    for (int i = 0; i < 16; i++) rand_op(1'b0, 1);
    check("wrap_end", 32'(op_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
